// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite channel bundle between one interconnect master port and its responder.
interface AXI_LITE;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register responder: N_RW control registers followed by N_RO status words,
// with per-access strobes for write-side effects and pop-on-read peripherals.
module axi_lite_reg_slave #(
    parameter int unsigned N_RW       = 4,
    parameter int unsigned N_RO       = 4,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    AXI_LITE.slave               axi,
    output logic [N_RW*32-1:0]   ctrl_o,
    input  logic [N_RO*32-1:0]   status_i,
    output logic                 wr_stb_o,
    output logic [5:0]           wr_idx_o,
    output logic                 rd_stb_o,
    output logic [5:0]           rd_idx_o
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic               alive;
    logic [0:0]         w_state;
    logic [0:0]         r_state;
    logic               aw_held;
    logic               w_held;
    logic [29:0]        aw_addr_q;
    logic [31:0]        w_data_q;
    logic [3:0]         w_strb_q;
    logic [1:0]         bresp_q;
    logic [31:0]        rdata_q;
    logic [1:0]         rresp_q;
    logic [N_RW*32-1:0] ctrl_q;

    logic               aw_hs;
    logic               w_hs;
    logic               ar_hs;
    logic               commit;
    logic [29:0]        wr_waddr;
    logic [31:0]        wr_data;
    logic [3:0]         wr_strb;
    logic [31:0]        wr_old;
    logic [31:0]        wr_mask;
    logic [31:0]        wr_new;
    logic [29:0]        ar_waddr;
    logic               ar_ok;
    logic [31:0]        rd_word;
    logic               unused_ok;

    // Word address decode: bits above the 64-word window must be zero.
    function automatic logic in_range(input logic [29:0] wa);
        return (wa[29:6] == '0) && (32'(wa[5:0]) < N_RW + N_RO);
    endfunction

    function automatic logic is_rw(input logic [29:0] wa);
        return (wa[29:6] == '0) && (32'(wa[5:0]) < N_RW);
    endfunction

    assign unused_ok = &{1'b0, axi.wlast, axi.awaddr[1:0], axi.araddr[1:0]};

    assign axi.awready = alive && !aw_held && (w_state == W_IDLE);
    assign axi.wready  = alive && !w_held  && (w_state == W_IDLE);
    assign axi.arready = alive && (r_state == R_IDLE);
    assign axi.bvalid  = (w_state == W_RESP);
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = (r_state == R_DATA);
    assign axi.rlast   = (r_state == R_DATA);
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign ctrl_o      = ctrl_q;

    assign aw_hs    = axi.awvalid && axi.awready;
    assign w_hs     = axi.wvalid && axi.wready;
    assign ar_hs    = axi.arvalid && axi.arready;
    // A channel that already handshook supplies its latched copy; otherwise the live bus.
    assign wr_waddr = aw_held ? aw_addr_q : axi.awaddr[31:2];
    assign wr_data  = w_held ? w_data_q : axi.wdata;
    assign wr_strb  = w_held ? w_strb_q : axi.wstrb;
    assign commit   = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign ar_waddr = axi.araddr[31:2];
    assign ar_ok    = in_range(ar_waddr);

    // Byte-lane merge of the write data into the addressed control register.
    always_comb begin
        wr_old  = '0;
        wr_mask = '0;
        for (int unsigned i = 0; i < N_RW; i++) begin
            if (wr_waddr[5:0] == 6'(i)) wr_old = ctrl_q[32*i +: 32];
        end
        for (int unsigned b = 0; b < 4; b++) begin
            wr_mask[8*b +: 8] = {8{wr_strb[b]}};
        end
        wr_new = (wr_old & ~wr_mask) | (wr_data & wr_mask);
    end

    // Read mux: control register, status word, or zero for an undecoded address.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < N_RW; i++) begin
            if (ar_waddr[5:0] == 6'(i)) rd_word = ctrl_q[32*i +: 32];
        end
        for (int unsigned j = 0; j < N_RO; j++) begin
            if (ar_waddr[5:0] == 6'(N_RW + j)) rd_word = status_i[32*j +: 32];
        end
        if (!ar_ok) rd_word = '0;
    end

    // Readies stay low until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    // Write channel: independent AW/W capture, commit, then hold B until bready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            wr_stb_o  <= 1'b0;
            wr_idx_o  <= '0;
        end else begin
            wr_stb_o <= 1'b0;
            if (w_state == W_IDLE) begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= axi.awaddr[31:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= axi.wdata;
                    w_strb_q <= axi.wstrb;
                end
                if (commit) begin
                    w_state <= W_RESP;
                    if (is_rw(wr_waddr)) begin
                        bresp_q  <= RESP_OKAY;
                        wr_stb_o <= 1'b1;
                        wr_idx_o <= wr_waddr[5:0];
                    end else begin
                        bresp_q <= RESP_SLVERR;
                    end
                end
            end else if (axi.bready) begin
                w_state <= W_IDLE;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Control register file, updated only on an OKAY commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= {N_RW{CTRL_RESET}};
        end else if (commit && is_rw(wr_waddr)) begin
            for (int unsigned i = 0; i < N_RW; i++) begin
                if (wr_waddr[5:0] == 6'(i)) ctrl_q[32*i +: 32] <= wr_new;
            end
        end
    end

    // Read channel: capture data at AR handshake (old value on a same-edge commit), hold until rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rd_stb_o <= 1'b0;
            rd_idx_o <= '0;
        end else begin
            rd_stb_o <= 1'b0;
            if (r_state == R_IDLE) begin
                if (ar_hs) begin
                    r_state <= R_DATA;
                    rdata_q <= rd_word;
                    rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                    if (ar_ok) begin
                        rd_stb_o <= 1'b1;
                        rd_idx_o <= ar_waddr[5:0];
                    end
                end
            end else if (axi.rready) begin
                r_state <= R_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed scenarios plus randomized
// traffic compared against an address-arithmetic model of the register map.
module tb_axi_lite_reg_slave;
    localparam int unsigned N_RW       = 4;
    localparam int unsigned N_RO       = 4;
    localparam logic [31:0] CTRL_RESET = 32'hA5A5_0F0F;
    localparam logic [1:0]  OKAY       = 2'b00;
    localparam logic [1:0]  SLVERR     = 2'b10;

    logic                clk;
    logic                rst_n;
    logic [N_RW*32-1:0]  ctrl_o;
    logic [N_RO*32-1:0]  status_i;
    logic                wr_stb_o;
    logic [5:0]          wr_idx_o;
    logic                rd_stb_o;
    logic [5:0]          rd_idx_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_ctrl   [4];
    logic [31:0] m_status [4];

    AXI_LITE bus ();

    axi_lite_reg_slave #(
        .N_RW       (N_RW),
        .N_RO       (N_RO),
        .CTRL_RESET (CTRL_RESET)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axi      (bus),
        .ctrl_o   (ctrl_o),
        .status_i (status_i),
        .wr_stb_o (wr_stb_o),
        .wr_idx_o (wr_idx_o),
        .rd_stb_o (rd_stb_o),
        .rd_idx_o (rd_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign status_i = {m_status[3], m_status[2], m_status[1], m_status[0]};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] exp_ctrl();
        return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
    endfunction

    // Byte addresses below 4*N_RW are writable; everything else answers SLVERR.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < 32'(4 * N_RW)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_ctrl[a[3:2]][8*b +: 8] = d[8*b +: 8];
            end
            return OKAY;
        end
        return SLVERR;
    endfunction

    function automatic logic [1:0] model_read(input logic [31:0] a, output logic [31:0] d);
        if (a < 32'(4 * N_RW)) begin
            d = m_ctrl[a[3:2]];
            return OKAY;
        end
        if (a < 32'(4 * (N_RW + N_RO))) begin
            d = m_status[a[3:2]];
            return OKAY;
        end
        d = '0;
        return SLVERR;
    endfunction

    task automatic bus_idle();
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    endtask

    // Drives one write with optional AW/W lead and bready stall; reports what it observed.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay, input int b_delay,
                             output logic [1:0] resp, output logic stb, output logic [5:0] idx,
                             output int hs_cycles, output int b_cycles, output bit proto_ok, output bit timeout);
        bit aw_done, w_done, aw_hs, w_hs;
        aw_done = 0; w_done = 0; hs_cycles = 0; b_cycles = 0; proto_ok = 1; timeout = 0;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb; bus.wlast = 1'b1;
        while (!(aw_done && w_done) && !timeout) begin
            bus.awvalid = !aw_done && (hs_cycles >= aw_delay);
            bus.wvalid  = !w_done && (hs_cycles >= w_delay);
            #1;
            if ((aw_done && bus.awready) || (w_done && bus.wready) || bus.bvalid || wr_stb_o) proto_ok = 0;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge clk);
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            hs_cycles++;
            if (hs_cycles > 100) timeout = 1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        resp = bus.bresp; stb = wr_stb_o; idx = wr_idx_o;
        for (int d = 0; d < b_delay; d++) begin
            if (bus.bvalid) b_cycles++;
            if (bus.bresp !== resp) proto_ok = 0;
            @(negedge clk);
            if (wr_stb_o) proto_ok = 0;
        end
        if (bus.bvalid) b_cycles++;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        if (bus.bvalid || wr_stb_o) proto_ok = 0;
    endtask

    // Drives one read with an optional rready stall; reports the captured beat.
    task automatic axi_read(input logic [31:0] addr, input int r_delay,
                            output logic [31:0] data, output logic [1:0] resp, output logic last,
                            output logic stb, output logic [5:0] idx, output bit proto_ok, output bit timeout);
        int cyc;
        cyc = 0; proto_ok = 1; timeout = 0;
        bus.araddr = addr; bus.arvalid = 1'b1;
        #1;
        while (!bus.arready && !timeout) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc > 100) timeout = 1;
        end
        if (bus.rvalid) proto_ok = 0;
        @(negedge clk);
        bus.arvalid = 1'b0;
        data = bus.rdata; resp = bus.rresp; last = bus.rlast; stb = rd_stb_o; idx = rd_idx_o;
        if (!bus.rvalid) proto_ok = 0;
        for (int d = 0; d < r_delay; d++) begin
            @(negedge clk);
            if (!bus.rvalid || bus.rdata !== data || bus.rresp !== resp || rd_stb_o) proto_ok = 0;
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        if (bus.rvalid || rd_stb_o) proto_ok = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin n_errors++;
            $display("FAIL reset_readies: got %b expected 000", {bus.awready, bus.wready, bus.arready}); end
        n_checks++; if ({bus.bvalid, bus.rvalid, bus.rlast, bus.bresp} !== 5'b0) begin n_errors++;
            $display("FAIL reset_resp: got %b expected 00000", {bus.bvalid, bus.rvalid, bus.rlast, bus.bresp}); end
        n_checks++; if (bus.rdata !== 32'h0) begin n_errors++;
            $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata); end
        n_checks++; if (ctrl_o !== exp_ctrl()) begin n_errors++;
            $display("FAIL reset_ctrl: got %h expected %h", ctrl_o, exp_ctrl()); end
        n_checks++; if ({wr_stb_o, rd_stb_o} !== 2'b00) begin n_errors++;
            $display("FAIL reset_strobes: got %b expected 00", {wr_stb_o, rd_stb_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin n_errors++;
            $display("FAIL release_readies_early: got %b expected 000", {bus.awready, bus.wready, bus.arready}); end
        @(negedge clk);
        #1;
        n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_errors++;
            $display("FAIL release_readies: got %b expected 111", {bus.awready, bus.wready, bus.arready}); end
    endtask

    task automatic test_same_cycle_write();
        logic [1:0] resp; logic stb; logic [5:0] idx; int hs, bc; bit pok, to;
        logic [1:0] mresp;
        @(negedge clk);
        axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, stb, idx, hs, bc, pok, to);
        mresp = model_write(32'h04, 32'hDEADBEEF, 4'hF);
        n_checks++; if (to || hs != 1 || bc != 1) begin n_errors++;
            $display("FAIL same_cycle_latency: got timeout=%0d hs=%0d bvalid_cycles=%0d expected 0 1 1", to, hs, bc); end
        n_checks++; if (resp !== mresp) begin n_errors++;
            $display("FAIL same_cycle_bresp: got %b expected %b", resp, mresp); end
        n_checks++; if (ctrl_o[63:32] !== 32'hDEADBEEF || ctrl_o !== exp_ctrl()) begin n_errors++;
            $display("FAIL same_cycle_ctrl: got %h expected %h", ctrl_o, exp_ctrl()); end
        n_checks++; if (stb !== 1'b1 || idx !== 6'd1) begin n_errors++;
            $display("FAIL same_cycle_wr_stb: got stb=%b idx=%0d expected 1 1", stb, idx); end
        n_checks++; if (!pok) begin n_errors++;
            $display("FAIL same_cycle_protocol: got 0 expected 1"); end
    endtask

    task automatic test_split_write();
        logic [1:0] resp; logic stb; logic [5:0] idx; int hs, bc; bit pok, to;
        logic [1:0] mresp;
        axi_write(32'h00, 32'h12345678, 4'hF, 3, 0, 5, resp, stb, idx, hs, bc, pok, to);
        mresp = model_write(32'h00, 32'h12345678, 4'hF);
        n_checks++; if (to || hs != 4) begin n_errors++;
            $display("FAIL split_handshake: got timeout=%0d hs=%0d expected 0 4", to, hs); end
        n_checks++; if (bc != 6) begin n_errors++;
            $display("FAIL split_bvalid_hold: got %0d cycles expected 6", bc); end
        n_checks++; if (!pok) begin n_errors++;
            $display("FAIL split_protocol: got 0 expected 1 (wready low after W, bvalid stable)"); end
        n_checks++; if (resp !== mresp || ctrl_o[31:0] !== 32'h12345678 || ctrl_o !== exp_ctrl()) begin n_errors++;
            $display("FAIL split_result: got resp=%b ctrl=%h expected resp=%b ctrl=%h", resp, ctrl_o, mresp, exp_ctrl()); end
        n_checks++; if (stb !== 1'b1 || idx !== 6'd0) begin n_errors++;
            $display("FAIL split_wr_stb: got stb=%b idx=%0d expected 1 0", stb, idx); end
    endtask

    task automatic test_status_read();
        logic [31:0] data; logic [1:0] resp; logic last, stb; logic [5:0] idx; bit pok, to;
        m_status[0] = 32'hCAFE0001;
        axi_read(32'h10, 2, data, resp, last, stb, idx, pok, to);
        n_checks++; if (to || !pok) begin n_errors++;
            $display("FAIL status_protocol: got timeout=%0d ok=%0d expected 0 1", to, pok); end
        n_checks++; if (data !== 32'hCAFE0001 || resp !== OKAY || last !== 1'b1) begin n_errors++;
            $display("FAIL status_beat: got data=%h resp=%b last=%b expected cafe0001 00 1", data, resp, last); end
        n_checks++; if (stb !== 1'b1 || idx !== 6'd4) begin n_errors++;
            $display("FAIL status_rd_stb: got stb=%b idx=%0d expected 1 4", stb, idx); end
    endtask

    task automatic test_errors();
        logic [31:0] waddr [5];
        logic [31:0] raddr [7];
        logic [1:0] resp, mresp; logic stb, last; logic [5:0] idx; int hs, bc; bit pok, to;
        logic [31:0] data, mdata;
        waddr = '{32'h14, 32'h10, 32'h1C, 32'h104, 32'h8000_0000};
        raddr = '{32'h80, 32'h20, 32'h104, 32'h1C, 32'h0F, 32'h14, 32'h1F};
        foreach (waddr[i]) begin
            axi_write(waddr[i], $urandom(), 4'hF, 0, 0, 0, resp, stb, idx, hs, bc, pok, to);
            mresp = model_write(waddr[i], 32'h0, 4'h0);
            n_checks++; if (to || !pok || resp !== mresp || stb !== 1'b0 || ctrl_o !== exp_ctrl()) begin n_errors++;
                $display("FAIL err_write %h: got resp=%b stb=%b ok=%0d ctrl=%h expected resp=%b stb=0 ok=1 ctrl=%h",
                         waddr[i], resp, stb, pok, ctrl_o, mresp, exp_ctrl()); end
        end
        foreach (raddr[i]) begin
            mresp = model_read(raddr[i], mdata);
            axi_read(raddr[i], 0, data, resp, last, stb, idx, pok, to);
            n_checks++; if (to || !pok || resp !== mresp || data !== mdata || stb !== (mresp == OKAY)) begin n_errors++;
                $display("FAIL err_read %h: got resp=%b data=%h stb=%b ok=%0d expected resp=%b data=%h stb=%b ok=1",
                         raddr[i], resp, data, stb, pok, mresp, mdata, mresp == OKAY); end
            if (mresp == OKAY) begin
                n_checks++; if (idx !== raddr[i][7:2]) begin n_errors++;
                    $display("FAIL err_read_idx %h: got %0d expected %0d", raddr[i], idx, raddr[i][7:2]); end
            end
        end
    endtask

    task automatic test_collision();
        logic [1:0] resp, mresp; logic stb, last; logic [5:0] idx; int hs, bc; bit pok, to;
        logic [31:0] data, old;
        axi_write(32'h08, 32'h11, 4'hF, 0, 0, 0, resp, stb, idx, hs, bc, pok, to);
        mresp = model_write(32'h08, 32'h11, 4'hF);
        old = m_ctrl[2];
        bus.awaddr = 32'h08; bus.wdata = 32'hAAAA5555; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.araddr = 32'h08; bus.arvalid = 1'b1;
        #1;
        n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_errors++;
            $display("FAIL collision_readies: got %b expected 111", {bus.awready, bus.wready, bus.arready}); end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        mresp = model_write(32'h08, 32'hAAAA5555, 4'hF);
        n_checks++; if (bus.rdata !== old || bus.rvalid !== 1'b1) begin n_errors++;
            $display("FAIL collision_old_value: got rdata=%h rvalid=%b expected %h 1", bus.rdata, bus.rvalid, old); end
        n_checks++; if (bus.bvalid !== 1'b1 || bus.bresp !== mresp || {wr_stb_o, rd_stb_o} !== 2'b11) begin n_errors++;
            $display("FAIL collision_write: got bvalid=%b bresp=%b stbs=%b expected 1 %b 11",
                     bus.bvalid, bus.bresp, {wr_stb_o, rd_stb_o}, mresp); end
        n_checks++; if (ctrl_o !== exp_ctrl()) begin n_errors++;
            $display("FAIL collision_ctrl: got %h expected %h", ctrl_o, exp_ctrl()); end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        n_checks++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin n_errors++;
            $display("FAIL collision_complete: got %b expected 00", {bus.bvalid, bus.rvalid}); end
        axi_read(32'h08, 0, data, resp, last, stb, idx, pok, to);
        n_checks++; if (to || data !== 32'hAAAA5555 || resp !== OKAY) begin n_errors++;
            $display("FAIL collision_readback: got %h resp=%b expected aaaa5555 00", data, resp); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp, mresp; logic stb, last; logic [5:0] idx; int hs, bc; bit pok, to;
        logic [31:0] addr, wd, data, mdata;
        for (int i = 0; i < 4; i++) begin
            addr = 32'(4 * i);
            wd = $urandom();
            axi_write(addr, wd, 4'hF, 0, 0, 0, resp, stb, idx, hs, bc, pok, to);
            mresp = model_write(addr, wd, 4'hF);
            n_checks++; if (to || hs != 1 || resp !== mresp || !pok || ctrl_o !== exp_ctrl()) begin n_errors++;
                $display("FAIL b2b_write %0d: got hs=%0d resp=%b ok=%0d ctrl=%h expected 1 %b 1 %h",
                         i, hs, resp, pok, ctrl_o, mresp, exp_ctrl()); end
        end
        for (int i = 0; i < 4; i++) begin
            addr = 32'(4 * (3 - i));
            mresp = model_read(addr, mdata);
            axi_read(addr, 0, data, resp, last, stb, idx, pok, to);
            n_checks++; if (to || !pok || data !== mdata || resp !== mresp) begin n_errors++;
                $display("FAIL b2b_read %0d: got data=%h resp=%b ok=%0d expected %h %b 1", i, data, resp, pok, mdata, mresp); end
        end
    endtask

    task automatic test_random();
        logic [1:0] resp, mresp; logic stb, last; logic [5:0] idx; int hs, bc; bit pok, to;
        logic [31:0] addr, wd, data, mdata;
        logic [3:0] strb;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) m_status[$urandom_range(0, 3)] = $urandom();
            case ($urandom_range(0, 3))
                0, 1:    addr = 32'($urandom_range(0, 31));
                2:       addr = 32'($urandom_range(32, 255));
                default: addr = $urandom() | 32'h100;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom();
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, wd, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          resp, stb, idx, hs, bc, pok, to);
                mresp = model_write(addr, wd, strb);
                n_checks++; if (to || !pok || resp !== mresp || stb !== (mresp == OKAY) || ctrl_o !== exp_ctrl()) begin n_errors++;
                    $display("FAIL rand_write %h: got resp=%b stb=%b ok=%0d ctrl=%h expected %b %b 1 %h",
                             addr, resp, stb, pok, ctrl_o, mresp, mresp == OKAY, exp_ctrl()); end
                if (mresp == OKAY) begin
                    n_checks++; if (idx !== addr[7:2]) begin n_errors++;
                        $display("FAIL rand_write_idx %h: got %0d expected %0d", addr, idx, addr[7:2]); end
                end
            end else begin
                mresp = model_read(addr, mdata);
                axi_read(addr, $urandom_range(0, 3), data, resp, last, stb, idx, pok, to);
                n_checks++; if (to || !pok || resp !== mresp || data !== mdata || last !== 1'b1 || stb !== (mresp == OKAY)) begin n_errors++;
                    $display("FAIL rand_read %h: got data=%h resp=%b last=%b stb=%b ok=%0d expected %h %b 1 %b 1",
                             addr, data, resp, last, stb, pok, mdata, mresp, mresp == OKAY); end
                if (mresp == OKAY) begin
                    n_checks++; if (idx !== addr[7:2]) begin n_errors++;
                        $display("FAIL rand_read_idx %h: got %0d expected %0d", addr, idx, addr[7:2]); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] resp, mresp; logic stb; logic [5:0] idx; int hs, bc; bit pok, to;
        axi_write(32'h0C, 32'h0BADF00D, 4'hF, 0, 0, 0, resp, stb, idx, hs, bc, pok, to);
        mresp = model_write(32'h0C, 32'h0BADF00D, 4'hF);
        bus.araddr = 32'h0C; bus.arvalid = 1'b1; bus.rready = 1'b0;
        bus.awaddr = 32'h04; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        n_checks++; if (bus.rvalid !== 1'b1) begin n_errors++;
            $display("FAIL midreset_pre_rvalid: got %b expected 1", bus.rvalid); end
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) m_ctrl[i] = CTRL_RESET;
        #1;
        n_checks++; if ({bus.rvalid, bus.bvalid, rd_stb_o, wr_stb_o} !== 4'b0000) begin n_errors++;
            $display("FAIL midreset_valids: got %b expected 0000", {bus.rvalid, bus.bvalid, rd_stb_o, wr_stb_o}); end
        n_checks++; if (ctrl_o !== exp_ctrl()) begin n_errors++;
            $display("FAIL midreset_ctrl: got %h expected %h", ctrl_o, exp_ctrl()); end
        n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin n_errors++;
            $display("FAIL midreset_readies: got %b expected 000", {bus.awready, bus.wready, bus.arready}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if ({bus.awready, bus.wready, bus.arready, bus.rvalid, bus.bvalid} !== 5'b11100) begin n_errors++;
            $display("FAIL midreset_release: got %b expected 11100", {bus.awready, bus.wready, bus.arready, bus.rvalid, bus.bvalid}); end
        // A lone W after reset must not pair with the AW that was pending before it.
        @(negedge clk);
        bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.bvalid !== 1'b0 || ctrl_o !== exp_ctrl()) begin n_errors++;
            $display("FAIL midreset_no_stale_aw: got bvalid=%b ctrl=%h expected 0 %h", bus.bvalid, ctrl_o, exp_ctrl()); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_ctrl[i]   = CTRL_RESET;
            m_status[i] = $urandom();
        end
        rst_n = 1'b0;
        bus_idle();
        test_reset();
        test_same_cycle_write();
        test_split_write();
        test_status_read();
        test_errors();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
